circular_buffer_read_master: RTL

- Consumer-side controller for the circular buffer's read port. It drives `read_enable`, waits for the buffer's `valid`, captures the word, then releases `read_enable` so the buffer advances its read pointer.
- On a single `start` it fetches a burst of `count` words.
- Each word is presented downstream over a valid/ready handshake with backpressure, and `done` pulses at the end of the burst.
- Sits between the circular buffer and the PE datapath that consumes buffered operands.

---
 rtl/circular_buffer_read_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/circular_buffer_read_master.sv
// circular_buffer_read_master
//   Consumer-side controller for the circular buffer read port. On start it
//   fetches a burst of `count` words. For each word it raises read_enable,
//   waits for the buffer's valid, captures rdata, then drops read_enable so
//   the buffer advances its read pointer. Each captured word is offered
//   downstream on a valid/ready handshake. done pulses at the end of the burst.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   start, count      burst request and length (sampled in IDLE only)
//   empty, valid,     buffer status and read data
//   rdata
//   read_enable       read request to the buffer
//   dout, dout_valid, captured word and downstream handshake
//   dout_ready
//   busy, done        status; done is a one-cycle completion pulse
//   words_read        words accepted downstream in the current/last burst
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// CHECK    | waiting for the buffer to be non-empty
// REQ      | read_enable high, waiting for buffer valid
// RELEASE  | read_enable dropped; buffer moves to pointer update
// SETTLE   | buffer updates its read pointer so empty is current
// PRESENT  | dout_valid high until downstream accepts
// FINISH   | done pulse, back to IDLE

module circular_buffer_read_master #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              empty,
  input  logic              valid,
  input  logic [DATA_W-1:0] rdata,
  output logic              read_enable,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_read
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_RELEASE,
    S_SETTLE,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;

  // Outputs are registered: each branch sets the value that belongs to the
  // state being entered. read_enable, dout_valid and done default low so
  // they can only be high in REQ, PRESENT and FINISH respectively.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      read_enable <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      words_read  <= '0;
    end else begin
      read_enable <= 1'b0;
      dout_valid  <= 1'b0;
      done        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            words_read <= '0;
            busy       <= 1'b1;
            if (count != '0) begin
              remaining <= count;
              state     <= S_CHECK;
            end else begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= S_FINISH;
            end
          end
        end

        S_CHECK: begin
          if (!empty) begin
            read_enable <= 1'b1;
            state       <= S_REQ;
          end
        end

        // valid may arrive late when the buffer services a write first;
        // read_enable stays high continuously until it does.
        S_REQ: begin
          if (valid) begin
            dout  <= rdata;
            state <= S_RELEASE;
          end else begin
            read_enable <= 1'b1;
          end
        end

        S_RELEASE: begin
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          dout_valid <= 1'b1;
          state      <= S_PRESENT;
        end

        S_PRESENT: begin
          if (dout_ready) begin
            words_read <= words_read + CNT_W'(1);
            remaining  <= remaining - CNT_W'(1);
            if (remaining > CNT_W'(1)) begin
              state <= S_CHECK;
            end else begin
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end else begin
            dout_valid <= 1'b1;
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
